// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared ALU codes, selector encodings and pipeline register layouts
package ex_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        BR_EQ   = 2'b00,
        BR_NONE = 2'b01,
        BR_LT   = 2'b10,
        BR_LTU  = 2'b11
    } br_type_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic            jalr;
        br_type_t        br_type;
        logic            inv_br;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
    } exmem_t;

    // The reserved selector 11 falls back to the register-file value.
    function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t sel,
                                                input logic [XLEN-1:0] reg_val,
                                                input logic [XLEN-1:0] w_val,
                                                input logic [XLEN-1:0] m_val);
        case (sel)
            FWD_W:   return w_val;
            FWD_M:   return m_val;
            default: return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - decode-side inputs, hazard controls and EX/MEM outputs of the execute stage
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic            StallE, FlushE, ValidD;
    logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic [3:0]      ALUControlD;
    logic            ALUSrcD, BranchD, JumpD, JalrD;
    logic [1:0]      BrTypeD;
    logic            InverseBrCondD, RegWriteD, MemWriteD;
    logic [1:0]      ResultSrcD;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [XLEN-1:0] ResultW;

    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            ValidM, RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;

    modport master (
        output StallE, FlushE, ValidD, RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD,
               ALUControlD, ALUSrcD, BranchD, JumpD, JalrD, BrTypeD, InverseBrCondD,
               RegWriteD, MemWriteD, ResultSrcD, ForwardAE, ForwardBE, ResultW,
        input  Rs1E, Rs2E, RdE, PCSrcE, PCTargetE, ValidM, RegWriteM, MemWriteM,
               ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  StallE, FlushE, ValidD, RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD,
               ALUControlD, ALUSrcD, BranchD, JumpD, JalrD, BrTypeD, InverseBrCondD,
               RegWriteD, MemWriteD, ResultSrcD, ForwardAE, ForwardBE, ResultW,
        output Rs1E, Rs2E, RdE, PCSrcE, PCTargetE, ValidM, RegWriteM, MemWriteM,
               ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational RV32I ALU driven by the 4-bit control code
module ex_stage_alu
    import ex_stage_pkg::*;
(
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic [3:0]      i_alu_ctrl,
    output logic [XLEN-1:0] o_result
);

    logic [4:0] w_shamt;
    logic       w_lt;
    logic       w_ltu;

    assign w_shamt = i_src_b[4:0];
    assign w_lt    = $signed(i_src_a) < $signed(i_src_b);
    assign w_ltu   = i_src_a < i_src_b;

    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            ALU_ADD:  o_result = i_src_a + i_src_b;
            ALU_SUB:  o_result = i_src_a - i_src_b;
            ALU_SLL:  o_result = i_src_a << w_shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_ltu};
            ALU_XOR:  o_result = i_src_a ^ i_src_b;
            ALU_SRL:  o_result = i_src_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_src_a) >>> w_shamt);
            ALU_OR:   o_result = i_src_a | i_src_b;
            ALU_AND:  o_result = i_src_a & i_src_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: ID/EX register, forwarding, ALU, branch resolve, EX/MEM register
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    idex_t           r_idex;
    idex_t           w_idex_d;
    exmem_t          r_exmem;
    exmem_t          w_exmem_d;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_br_raw;
    logic            w_br_cond;

    always_comb begin
        w_idex_d            = '0;
        w_idex_d.valid      = bus.ValidD;
        w_idex_d.rd1        = bus.RD1D;
        w_idex_d.rd2        = bus.RD2D;
        w_idex_d.pc         = bus.PCD;
        w_idex_d.imm        = bus.ImmExtD;
        w_idex_d.rs1        = bus.Rs1D;
        w_idex_d.rs2        = bus.Rs2D;
        w_idex_d.rd         = bus.RdD;
        w_idex_d.alu_ctrl   = bus.ALUControlD;
        w_idex_d.alu_src    = bus.ALUSrcD;
        w_idex_d.branch     = bus.BranchD;
        w_idex_d.jump       = bus.JumpD;
        w_idex_d.jalr       = bus.JalrD;
        w_idex_d.br_type    = br_type_t'(bus.BrTypeD);
        w_idex_d.inv_br     = bus.InverseBrCondD;
        w_idex_d.reg_write  = bus.RegWriteD;
        w_idex_d.mem_write  = bus.MemWriteD;
        w_idex_d.result_src = bus.ResultSrcD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.FlushE) begin
            r_idex <= '0;
        end else if (!bus.StallE) begin
            r_idex <= w_idex_d;
        end
    end

    assign w_fwd_a = fwd_mux(fwd_sel_t'(bus.ForwardAE), r_idex.rd1, bus.ResultW, r_exmem.alu_result);
    assign w_fwd_b = fwd_mux(fwd_sel_t'(bus.ForwardBE), r_idex.rd2, bus.ResultW, r_exmem.alu_result);
    assign w_src_b = r_idex.alu_src ? r_idex.imm : w_fwd_b;

    ex_stage_alu u_alu (
        .i_src_a    (w_fwd_a),
        .i_src_b    (w_src_b),
        .i_alu_ctrl (r_idex.alu_ctrl),
        .o_result   (w_alu_result)
    );

    always_comb begin
        w_br_raw = 1'b0;
        case (r_idex.br_type)
            BR_EQ:   w_br_raw = (w_fwd_a == w_src_b);
            BR_LT:   w_br_raw = ($signed(w_fwd_a) < $signed(w_src_b));
            BR_LTU:  w_br_raw = (w_fwd_a < w_src_b);
            default: w_br_raw = 1'b0;
        endcase
    end

    assign w_br_cond  = w_br_raw ^ r_idex.inv_br;
    assign w_jalr_sum = w_fwd_a + r_idex.imm;

    assign bus.PCSrcE    = r_idex.valid & (r_idex.jump | (r_idex.branch & w_br_cond));
    assign bus.PCTargetE = r_idex.jalr ? (w_jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                       : (r_idex.pc + r_idex.imm);

    // A stalled E slot stays put for the next cycle, so it must not also retire into M now.
    always_comb begin
        w_exmem_d            = '0;
        w_exmem_d.valid      = r_idex.valid & ~bus.StallE;
        w_exmem_d.reg_write  = r_idex.valid & ~bus.StallE & r_idex.reg_write;
        w_exmem_d.mem_write  = r_idex.valid & ~bus.StallE & r_idex.mem_write;
        w_exmem_d.result_src = r_idex.result_src;
        w_exmem_d.rd         = r_idex.rd;
        w_exmem_d.alu_result = w_alu_result;
        w_exmem_d.write_data = w_fwd_b;
        w_exmem_d.pc_plus4   = r_idex.pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_exmem_d;
        end
    end

    assign bus.Rs1E       = r_idex.rs1;
    assign bus.Rs2E       = r_idex.rs2;
    assign bus.RdE        = r_idex.rd;
    assign bus.ValidM     = r_exmem.valid;
    assign bus.RegWriteM  = r_exmem.reg_write;
    assign bus.MemWriteM  = r_exmem.mem_write;
    assign bus.ResultSrcM = r_exmem.result_src;
    assign bus.RdM        = r_exmem.rd;
    assign bus.ALUResultM = r_exmem.alu_result;
    assign bus.WriteDataM = r_exmem.write_data;
    assign bus.PCPlus4M   = r_exmem.pc_plus4;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage against a behavioural pipeline model
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    bit   started;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] rd1, rd2, pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        alusrc, br, j, jalr;
        logic [1:0]  bt;
        logic        inv, rw, mw;
        logic [1:0]  rs;
    } e_t;

    e_t          me;
    logic        mm_v, mm_rw, mm_mw;
    logic [1:0]  mm_rs;
    logic [4:0]  mm_rd;
    logic [31:0] mm_alu, mm_wd, mm_pc4;
    logic [31:0] p_fa, p_fb, p_sb;
    logic [31:0] c_fa, c_fb, c_sb, c_tgt;
    logic        c_cond, c_pcsrc;

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference pipeline: advances on every rising edge from the inputs the bench drove.
    always @(posedge clk) begin
        if (!rst_n) begin
            me = '0;
            {mm_v, mm_rw, mm_mw, mm_rs, mm_rd, mm_alu, mm_wd, mm_pc4} = '0;
        end else begin
            p_fa = fwd(bus.ForwardAE, me.rd1, bus.ResultW, mm_alu);
            p_fb = fwd(bus.ForwardBE, me.rd2, bus.ResultW, mm_alu);
            p_sb = me.alusrc ? me.imm : p_fb;
            mm_alu = alu_ref(me.alu, p_fa, p_sb);
            mm_wd  = p_fb;
            mm_pc4 = me.pc + 32'd4;
            mm_rd  = me.rd;
            mm_rs  = me.rs;
            mm_v   = me.v && !bus.StallE;
            mm_rw  = mm_v && me.rw;
            mm_mw  = mm_v && me.mw;
            if (bus.FlushE) me = '0;
            else if (!bus.StallE)
                me = '{bus.ValidD, bus.RD1D, bus.RD2D, bus.PCD, bus.ImmExtD, bus.Rs1D, bus.Rs2D,
                       bus.RdD, bus.ALUControlD, bus.ALUSrcD, bus.BranchD, bus.JumpD, bus.JalrD,
                       bus.BrTypeD, bus.InverseBrCondD, bus.RegWriteD, bus.MemWriteD, bus.ResultSrcD};
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            c_fa = fwd(bus.ForwardAE, me.rd1, bus.ResultW, mm_alu);
            c_fb = fwd(bus.ForwardBE, me.rd2, bus.ResultW, mm_alu);
            c_sb = me.alusrc ? me.imm : c_fb;
            case (me.bt)
                2'd0:    c_cond = (c_fa == c_sb);
                2'd2:    c_cond = ($signed(c_fa) < $signed(c_sb));
                2'd3:    c_cond = (c_fa < c_sb);
                default: c_cond = 1'b0;
            endcase
            c_cond  = c_cond ^ me.inv;
            c_pcsrc = me.v && (me.j || (me.br && c_cond));
            c_tgt   = me.jalr ? ((c_fa + me.imm) & 32'hFFFF_FFFE) : (me.pc + me.imm);
            chk("Rs1E", 32'(bus.Rs1E), 32'(me.rs1));
            chk("Rs2E", 32'(bus.Rs2E), 32'(me.rs2));
            chk("RdE", 32'(bus.RdE), 32'(me.rd));
            chk("PCSrcE", 32'(bus.PCSrcE), 32'(c_pcsrc));
            chk("PCTargetE", bus.PCTargetE, c_tgt);
            chk("ValidM", 32'(bus.ValidM), 32'(mm_v));
            chk("RegWriteM", 32'(bus.RegWriteM), 32'(mm_rw));
            chk("MemWriteM", 32'(bus.MemWriteM), 32'(mm_mw));
            chk("ResultSrcM", 32'(bus.ResultSrcM), 32'(mm_rs));
            chk("RdM", 32'(bus.RdM), 32'(mm_rd));
            chk("ALUResultM", bus.ALUResultM, mm_alu);
            chk("WriteDataM", bus.WriteDataM, mm_wd);
            chk("PCPlus4M", bus.PCPlus4M, mm_pc4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        bus.StallE = 0; bus.FlushE = 0; bus.ValidD = 0;
        bus.RD1D = 0; bus.RD2D = 0; bus.PCD = 0; bus.ImmExtD = 0;
        bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0; bus.ALUControlD = 0;
        bus.ALUSrcD = 0; bus.BranchD = 0; bus.JumpD = 0; bus.JalrD = 0;
        bus.BrTypeD = 0; bus.InverseBrCondD = 0; bus.RegWriteD = 0; bus.MemWriteD = 0;
        bus.ResultSrcD = 0; bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
    endtask

    task automatic rand_d();
        bus.ValidD = 1'($urandom); bus.RD1D = $urandom; bus.RD2D = $urandom;
        if ($urandom_range(0, 3) == 0) bus.RD2D = bus.RD1D;
        bus.PCD = $urandom; bus.ImmExtD = $urandom;
        bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom); bus.RdD = 5'($urandom);
        bus.ALUControlD = 4'($urandom); bus.ALUSrcD = 1'($urandom);
        bus.BranchD = 1'($urandom); bus.JumpD = ($urandom_range(0, 3) == 0);
        bus.JalrD = 1'($urandom); bus.BrTypeD = 2'($urandom);
        bus.InverseBrCondD = 1'($urandom); bus.RegWriteD = 1'($urandom);
        bus.MemWriteD = 1'($urandom); bus.ResultSrcD = 2'($urandom);
        bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom); bus.ResultW = $urandom;
    endtask

    logic [31:0] sweep_exp [10];

    initial begin
        n_cmp = 0; n_fail = 0; started = 0;
        sweep_exp = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FF00, 32'h1, 32'h0,
                      32'hFFFF_FFF4, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'h0};
        nop();
        rst_n = 0;
        rand_d();
        bus.ValidD = 1; bus.BranchD = 1; bus.JumpD = 1; bus.RegWriteD = 1;
        step(); step();
        chk("rst_ValidM", 32'(bus.ValidM), 0);
        chk("rst_RegWriteM", 32'(bus.RegWriteM), 0);
        chk("rst_ALUResultM", bus.ALUResultM, 0);
        chk("rst_PCSrcE", 32'(bus.PCSrcE), 0);
        rst_n = 1;
        nop();

        for (int i = 0; i < 11; i++) begin
            nop();
            bus.ValidD = 1; bus.RD1D = 32'hFFFF_FFF0; bus.RD2D = 32'h4;
            bus.ALUControlD = (i == 10) ? 4'd12 : 4'(i);
            step(); nop(); step();
            chk($sformatf("alu_code_%0d", (i == 10) ? 12 : i), bus.ALUResultM,
                (i == 10) ? 32'h0 : sweep_exp[i]);
        end

        nop(); bus.ValidD = 1; bus.BranchD = 1; bus.RD1D = 5; bus.RD2D = 5;
        bus.PCD = 32'h100; bus.ImmExtD = 32'h20;
        step();
        chk("beq_pcsrc", 32'(bus.PCSrcE), 1);
        chk("beq_target", bus.PCTargetE, 32'h120);
        bus.InverseBrCondD = 1;
        step();
        chk("bne_pcsrc", 32'(bus.PCSrcE), 0);
        bus.InverseBrCondD = 0; bus.RD1D = 32'hFFFF_FFFF; bus.RD2D = 1; bus.BrTypeD = 2'b10;
        step();
        chk("blt_pcsrc", 32'(bus.PCSrcE), 1);
        bus.BrTypeD = 2'b11;
        step();
        chk("bltu_pcsrc", 32'(bus.PCSrcE), 0);

        nop(); bus.ValidD = 1; bus.JumpD = 1; bus.JalrD = 1; bus.RD1D = 32'h203;
        bus.ImmExtD = 2; bus.PCD = 32'h300; bus.ResultSrcD = 2'b10;
        step();
        chk("jalr_target", bus.PCTargetE, 32'h204);
        chk("jalr_pcsrc", 32'(bus.PCSrcE), 1);
        nop(); step();
        chk("jalr_pcplus4", bus.PCPlus4M, 32'h304);

        nop(); bus.ValidD = 1; bus.RD1D = 32'h50; bus.ALUSrcD = 1;
        step();
        nop(); bus.ValidD = 1; bus.RD1D = 1; bus.ALUSrcD = 1;
        step();
        nop(); bus.ForwardAE = 2'b10; bus.ResultW = 32'h60;
        step();
        chk("fwd_m", bus.ALUResultM, 32'h50);
        for (int k = 0; k < 2; k++) begin
            nop(); bus.ValidD = 1; bus.RD1D = 1; bus.ALUSrcD = 1;
            step();
            nop(); bus.ForwardAE = (k == 0) ? 2'b01 : 2'b11; bus.ResultW = 32'h60;
            step();
            chk(k == 0 ? "fwd_w" : "fwd_rsvd", bus.ALUResultM, (k == 0) ? 32'h60 : 32'h1);
        end

        nop(); bus.ValidD = 1; bus.Rs1D = 7; bus.RdD = 9; bus.RegWriteD = 1;
        step();
        for (int k = 0; k < 2; k++) begin
            rand_d(); bus.ValidD = 1; bus.Rs1D = 3; bus.RdD = 4; bus.FlushE = 0; bus.StallE = 1;
            step();
            chk("stall_Rs1E", 32'(bus.Rs1E), 7);
            chk("stall_RdE", 32'(bus.RdE), 9);
            chk("stall_ValidM", 32'(bus.ValidM), 0);
            chk("stall_RegWriteM", 32'(bus.RegWriteM), 0);
        end
        nop();
        step();
        chk("unstall_ValidM", 32'(bus.ValidM), 1);
        chk("unstall_RdM", 32'(bus.RdM), 9);

        nop(); bus.ValidD = 1; bus.JumpD = 1; bus.Rs1D = 5; bus.FlushE = 1; bus.StallE = 1;
        step();
        chk("flush_PCSrcE", 32'(bus.PCSrcE), 0);
        chk("flush_Rs1E", 32'(bus.Rs1E), 0);
        nop();
        step();
        chk("flush_ValidM", 32'(bus.ValidM), 0);

        nop(); bus.ValidD = 1; bus.Rs1D = 11; step();
        bus.StallE = 1; rst_n = 0;
        step();
        chk("rststall_Rs1E", 32'(bus.Rs1E), 0);
        chk("rststall_ValidM", 32'(bus.ValidM), 0);
        rst_n = 1; nop();

        for (int c = 0; c < 3000; c++) begin
            rand_d();
            bus.StallE = ($urandom_range(0, 7) == 0);
            bus.FlushE = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 255) != 0);
            step();
        end
        rst_n = 1; nop();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the pipelined RV32I core, directly downstream of the ALU decoder.
- Latches decode-stage operands and control, including the 4-bit ALU control code and the inverse-branch-condition bit, into the ID/EX register.
- Applies operand forwarding, runs the ALU, resolves branches and jumps, and registers the results into the EX/MEM register.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- StallE  in  1  hold the ID/EX register
- FlushE  in  1  load a bubble into the ID/EX register
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D  in  XLEN  register-file operands
- PCD, ImmExtD  in  XLEN  instruction PC and extended immediate
- Rs1D, Rs2D, RdD  in  5  register indices
- ALUControlD  in  4  ALU operation code
- ALUSrcD  in  1  1 selects the immediate as SrcB
- BranchD, JumpD, JalrD  in  1  control-flow class
- BrTypeD  in  2  funct3[2:1]: 00 eq, 10 lt, 11 ltu
- InverseBrCondD  in  1  invert the branch condition
- RegWriteD, MemWriteD  in  1  write enables
- ResultSrcD  in  2  write-back select, passed through
- ForwardAE, ForwardBE  in  2  00 register value, 01 ResultW, 10 ALUResultM
- ResultW  in  XLEN  write-back value for forwarding
- Rs1E, Rs2E, RdE  out  5  to the hazard unit
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  redirect target (combinational)
- ValidM, RegWriteM, MemWriteM  out  1  EX/MEM register fields
- ResultSrcM  out  2  EX/MEM register field
- RdM  out  5  EX/MEM register field
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  EX/MEM register fields

Behaviour:
- Reset: when rst_n=0 at a clock edge, every ID/EX and EX/MEM field clears to 0, including all valid and enable bits.
- ID/EX register priority: FlushE, then StallE, then load from D.
  - FlushE loads a bubble: all fields 0.
  - StallE holds all fields.
- EX/MEM register: normally loads from E. While StallE=1, it loads a bubble instead (ValidM, RegWriteM, MemWriteM = 0).
- Forwarding mux, per operand: 00 gives RD*E, 01 gives ResultW, 10 gives ALUResultM, 11 is treated as 00. SrcA is the forwarded RD1. WriteData is the forwarded RD2. SrcB = ALUSrcE ? ImmExtE : WriteData.
- ALU codes, from the shared header:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Shift amount is SrcB[4:0].
  - SLT and SLTU return 0 or 1, zero-extended.
  - Codes 10–15 return 0.
  - All arithmetic wraps modulo 2^XLEN.
- Branch condition: the comparison selected by BrTypeE (equal / signed less-than / unsigned less-than) on SrcA vs SrcB, XORed with InverseBrCondE. BrTypeE=01 gives false before inversion.
- PCSrcE = ValidE & (JumpE | (BranchE & cond)). All E-stage hazard effects are gated by ValidE.
- PCTargetE:
  - JalrE=1: (SrcA + ImmExtE) with bit 0 cleared.
  - Otherwise: PCE + ImmExtE.
- Result into the EX/MEM register: PCPlus4M = PCE + 4. ALUResultM = the ALU output. For jumps the write-back source selects PCPlus4M via ResultSrc.
- Latency:
  - One cycle from D inputs to E.
  - One more cycle to the M outputs.
  - PCSrcE and PCTargetE are combinational from E-stage state in the same cycle.
- Simultaneous FlushE and StallE: flush wins.
- Reset mid-stall clears everything regardless of StallE or FlushE.

Decomposition:
- Shared package holds:
  - the ALU code constants (4-bit, values above),
  - the ForwardSel and BrType encodings,
  - a packed struct for the ID/EX fields and one for the EX/MEM fields.
- One natural sub-module: alu (combinational; SrcA, SrcB, ALUControl in; result out). Branch compare and forwarding stay in ex_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with nonzero D inputs -> all M outputs are 0, and PCSrcE=0 even when BranchD=1.
- ALU sweep, ALUSrcD=0, RD1=0xFFFFFFF0, RD2=0x00000004, each code 0–9 -> ALUResultM two cycles later:
  - 0xFFFFFFF4, 0xFFFFFFEC, 0xFFFFFF00, 1, 0, 0xFFFFFFF4, 0x0FFFFFFF, 0xFFFFFFFF, 0xFFFFFFF4, 0x00000000.
  - Code 12 -> 0.
- Branches, RD1=5, RD2=5, PCD=0x100, Imm=0x20:
  - BrType 00, Inv 0 -> PCSrcE=1, PCTargetE=0x120.
  - Inv 1 (bne) -> PCSrcE=0.
  - RD1=-1, RD2=1: BrType 10 -> taken; BrType 11 -> not taken.
- JALR with RD1=0x203 and Imm=2 -> PCTargetE=0x204, PCSrcE=1; two cycles later PCPlus4M = PCD + 4.
- Forwarding with RD1=1, ALUResultM=0x50, ResultW=0x60, ALU code ADD, Imm=0, ALUSrc=1:
  - ForwardAE=10 -> result 0x50.
  - ForwardAE=01 -> result 0x60.
  - ForwardAE=11 -> result 1.
- Hazards:
  - StallE for 2 cycles -> E fields hold and ValidM=0 in both following cycles.
  - FlushE and StallE together -> next cycle ValidE=0 and PCSrcE=0 even with JumpD=1.
